// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned IDX_W  = 2;

  // Access size/sign codes carried on req_bytes
  typedef enum logic [CODE_W-1:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } access_code_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Latched request attributes (address kept separately: its width is a parameter)
  typedef struct packed {
    logic              we;
    logic [CODE_W-1:0] code;
    logic [WORD_W-1:0] wd;
  } req_payload_t;

  // Number of byte accesses for a code; only the size bits matter
  function automatic logic [2:0] byte_count(input logic [CODE_W-1:0] code);
    logic [2:0] n;
    case (code[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Loads accept all five codes; stores have no unsigned variants
  function automatic logic code_valid(input logic [CODE_W-1:0] code, input logic we);
    logic ok;
    case (code)
      LB, LH, LW: ok = 1'b1;
      LBU, LHU:   ok = !we;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled little-endian load buffer.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [CODE_W-1:0] code,
  output logic [WORD_W-1:0] ext
);

  // Select width and extension from the access code; unknown codes yield 0
  always_comb begin
    ext = '0;
    case (code)
      LB:      ext = {{24{data[7]}}, data[7:0]};
      LH:      ext = {{16{data[15]}}, data[15:0]};
      LW:      ext = data;
      LBU:     ext = {24'd0, data[7:0]};
      LHU:     ext = {16'd0, data[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store initiator: one request is split into 1/2/4
// little-endian byte accesses to an asynchronous-read byte memory.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned h/w accesses
// with resp_err instead of performing them byte by byte.
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_bytes,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [31:0]        req_wd,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_wd,
  input  logic [D_WIDTH-1:0] mem_rdata
);

  state_e                 state;
  state_e                 state_nx;
  req_payload_t           req_q;
  logic [IDX_W-1:0]       idx;
  logic [3:0][BYTE_W-1:0] data_buf;
  logic [A_WIDTH-1:0]     mem_addr_q;
  logic [WORD_W-1:0]      ext_data;
  logic                   accept_c;
  logic                   skip_c;
  logic                   misalign_c;
  logic                   last_c;
  logic                   err_c;

  assign accept_c = req_valid && (state == IDLE);
  assign last_c   = (idx == IDX_W'(byte_count(req_q.code) - 3'd1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  // Halfwords need addr[0]==0, words need addr[1:0]==0
  assign misalign_c = ((req_bytes[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_bytes[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign err_c      = err_q;

  // Remember a trapped request for its single response cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept_c) begin
      err_q <= code_valid(req_bytes, req_we) && misalign_c;
    end
  end
`else
  assign misalign_c = 1'b0;
  assign err_c      = 1'b0;
`endif

  // Requests that go straight to RESP without touching memory
  assign skip_c = !code_valid(req_bytes, req_we) || misalign_c;

  lsu_extend u_extend (
    .data (data_buf),
    .code (req_q.code),
    .ext  (ext_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and outputs; every output is forced low while rst is high
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;

    case (state)
      IDLE:    if (accept_c) state_nx = skip_c ? RESP : ACCESS;
      ACCESS:  if (last_c) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (!rst) begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      mem_addr   = mem_addr_q;
      if ((state == ACCESS) && req_q.we) begin
        mem_we = 1'b1;
        mem_wd = D_WIDTH'(req_q.wd[{idx, 3'b000} +: BYTE_W]);
      end
      if ((state == RESP) && !req_q.we && !err_c) begin
        resp_rdata = ext_data;
      end
      resp_err = (state == RESP) && err_c;
    end
  end

  // Request latch, byte index, load buffer and memory address tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      idx        <= '0;
      data_buf   <= '0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            req_q.we   <= req_we;
            req_q.code <= req_bytes;
            req_q.wd   <= req_wd;
            idx        <= '0;
            data_buf   <= '0;
            if (!skip_c) mem_addr_q <= req_addr;
          end
        end
        ACCESS: begin
          if (!req_q.we) data_buf[idx] <= BYTE_W'(mem_rdata);
          idx <= idx + IDX_W'(1);
          // Stop advancing on the last byte so mem_addr holds it afterwards
          if (!last_c) mem_addr_q <= mem_addr_q + A_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_byte_serial.md
Name: lsu_byte_serial

Overview:
Load/store initiator between the CPU datapath and a byte-wide data memory (one byte per access, asynchronous read, write on posedge clk).
Accepts one load/store request per handshake and serialises it into 1, 2 or 4 little-endian byte accesses.
For loads, assembles the bytes and sign- or zero-extends the result; for stores, it splits the write data into bytes.
Returns a single-cycle completion pulse with the load data.

Parameters:
A_WIDTH, 32, address width of request and memory sides
D_WIDTH, 8, memory data width; fixed at 8, other values unsupported

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_bytes  in  3  access code: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  A_WIDTH  byte base address
req_wd  in  32  store data; low bytes used
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  misalignment flag; constant 0 unless MISALIGN_TRAP_EN
mem_addr  out  A_WIDTH  memory byte address
mem_we  out  1  memory write enable
mem_wd  out  D_WIDTH  memory write byte
mem_rdata  in  D_WIDTH  memory read byte, combinational from mem_addr

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- FSM states are IDLE, ACCESS and RESP. Reset enters IDLE.
- While rst is high, all outputs are driven 0, including req_ready.
- Reset values: req_ready=1 after reset releases; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_addr=0; mem_wd=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready the unit latches we, bytes, addr and wd, clears idx and the data buffer, and moves to ACCESS.
  - An unsupported code (011, 110, 111, or a store with 100/101) goes directly to RESP with no memory access and rdata=0.
- ACCESS:
  - req_ready=0.
  - Byte count n = 1/2/4 from bytes[1:0].
  - mem_addr = base+idx, computed modulo 2^A_WIDTH, so the address wraps from all-ones to 0.
  - Store: mem_we=1 and mem_wd = wd[8*idx+7:8*idx].
  - Load: mem_we=0, and buf[idx] <= mem_rdata at the clock edge.
  - idx increments each cycle. The state moves to RESP after idx == n-1.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata: b sign-extends buf[0]; h sign-extends {buf1,buf0}; w = {buf3..buf0}; bu/hu zero-extend; store gives 0.
  - The next state is IDLE. There is no response backpressure.
- Latency:
  - Request accepted at edge 0.
  - Memory bytes are accessed in cycles 1..n.
  - resp_valid is asserted in cycle n+1.
  - The next request is accepted no earlier than cycle n+2.
- req_valid while busy is ignored (req_ready=0); the requester holds it.
- Reset mid-operation: mem_we is gated by !rst in the same cycle, so no write is issued during a reset cycle. The partial store is abandoned, the buffer is cleared, and no resp_valid is produced.
- Outside ACCESS, mem_we=0 and mem_addr holds its last value.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - A halfword with addr[0]!=0, or a word with addr[1:0]!=0, skips ACCESS and goes to RESP.
  - In that RESP cycle resp_err=1 and resp_rdata=0. No memory byte is read or written.
- Undefined:
  - Misaligned accesses proceed byte-serially at any address.
  - resp_err is tied to 0.

Decomposition:
- lsu_pkg:
  - access-code enum: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - state enum: IDLE, ACCESS, RESP.
  - function byte_count(code) returning 1/2/4.
  - function code_valid(code, we).
- Sub-module lsu_extend:
  - combinational; inputs are the 32-bit buffer and the code; output is the extended 32-bit value.
  - instantiated once and driving resp_rdata.

Test Plan:
- Word store then load:
  - Store: addr=0x10, bytes=010, wd=0xDEADBEEF. Memory bytes 0x10..0x13 must be EF,BE,AD,DE, and resp_valid must appear in cycle 5.
  - Load: lw from 0x10 must return 0xDEADBEEF in cycle 5.
- Sign vs zero extension with byte 0x80 at addr 4:
  - lb must return 0xFFFFFF80; lbu must return 0x00000080; each with resp_valid in cycle 2.
- Halfword: sh wd=0x1234ABCD at addr 6, then lh -> 0xFFFFABCD and lhu -> 0x0000ABCD.
  - Memory[6]=CD, [7]=AB, [8] unchanged.
- Invalid code and busy:
  - bytes=011 load must give resp_valid in cycle 1 with rdata=0 and no mem_we.
  - req_valid held during a lw must not be accepted until cycle 6.
- Wrap and reset:
  - A sw at addr 0xFFFFFFFE must write bytes at FFFFFFFE, FFFFFFFF, 0, 1.
  - rst asserted in cycle 2 of a sw must leave only the first byte written, produce no resp_valid, and give req_ready=1 the cycle after rst falls.
- Misalignment, both ways:
  - With LSU_MISALIGN_TRAP_EN, lw at 0x3 must give resp_err=1 in cycle 1 with no memory access.
  - Without the macro it must complete normally in cycle 5.
